// File: rtl/cpu_dtack_ctrl_pkg.sv
// system_consts: shared constants for the 68000 bus glue.
//   cs_idx_t      - decoder select index (bit position in cs_n)
//   wait_class_t  - how a region completes a bus cycle
//   dtack_state_t - DTACK controller state encoding
//   REGION_CLASS  - per-region completion class
//   REGION_WAIT   - per-region fixed wait count, in cpu_ce pulses
//                   (ignored for WAIT_MEM regions)
package system_consts;

    localparam int NUM_REGIONS = 16;

    typedef enum logic [3:0] {
        CS_ROM        = 4'd0,
        CS_WORK       = 4'd1,
        CS_SCREEN0    = 4'd2,
        CS_SCREEN1    = 4'd3,
        CS_OBJECT     = 4'd4,
        CS_COLOR      = 4'd5,
        CS_IO0        = 4'd6,
        CS_IO1        = 4'd7,
        CS_SOUND      = 4'd8,
        CS_EXTENSION  = 4'd9,
        CS_PRIORITY   = 4'd10,
        CS_CCHIP      = 4'd11,
        CS_PIVOT      = 4'd12,
        CS_GROWL_HACK = 4'd13,
        CS_SS_SAVE    = 4'd14,
        CS_SS_VEC     = 4'd15
    } cs_idx_t;

    typedef enum logic {
        WAIT_FIXED = 1'b0,
        WAIT_MEM   = 1'b1
    } wait_class_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COUNT    = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_ACK      = 3'd3,
        ST_END      = 3'd4
    } dtack_state_t;

    // ROM and work RAM live in SDRAM; everything else is on-chip.
    localparam wait_class_t REGION_CLASS [NUM_REGIONS] = '{
        WAIT_MEM,   WAIT_MEM,   WAIT_FIXED, WAIT_FIXED,
        WAIT_FIXED, WAIT_FIXED, WAIT_FIXED, WAIT_FIXED,
        WAIT_FIXED, WAIT_FIXED, WAIT_FIXED, WAIT_FIXED,
        WAIT_FIXED, WAIT_FIXED, WAIT_FIXED, WAIT_FIXED
    };

    // A zero entry acknowledges on the clk after the cycle starts.
    localparam logic [3:0] REGION_WAIT [NUM_REGIONS] = '{
        4'd0, 4'd0, 4'd1, 4'd1,   // ROM, WORK, SCREEN0, SCREEN1
        4'd1, 4'd1, 4'd2, 4'd2,   // OBJECT, COLOR, IO0, IO1
        4'd3, 4'd0, 4'd1, 4'd4,   // SOUND, EXTENSION, PRIORITY, CCHIP
        4'd1, 4'd0, 4'd0, 4'd0    // PIVOT, GROWL_HACK, SS_SAVE, SS_VEC
    };

endpackage

// File: rtl/cpu_dtack_ctrl_enc.sv
// cs_priority_enc: fixed-priority encoder over active-low selects.
//   cs_n      - active-low selects, bit 0 has the highest priority
//   idx       - index of the lowest-numbered asserted select (0 if none)
//   any_valid - at least one select is asserted
module cs_priority_enc #(
    parameter int NUM_CS = 16
) (
    input  logic [NUM_CS-1:0]         cs_n,
    output logic [$clog2(NUM_CS)-1:0] idx,
    output logic                      any_valid
);

    localparam int IDX_W = $clog2(NUM_CS);

    // Scan high to low so the last hit written is the lowest index.
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (!cs_n[i]) begin
                idx       = IDX_W'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_dtack_ctrl.sv
// cpu_dtack_ctrl: generates 68000 DTACK from the address decoder selects.
// Fixed-wait regions count cpu_ce pulses; SDRAM regions handshake with
// the arbiter through mem_req/mem_ack; a timeout and an unmapped-access
// path guarantee the CPU always gets DTACK.
//   clk, reset   - system clock, async active-high reset
//   cpu_ce       - one-clk enable per CPU clock (wait counting unit)
//   cpu_as_n     - address strobe; cpu_ds_n {UDS, LDS} data strobes
//   cs_n         - active-low region selects, indexed by cs_idx_t
//   mem_ack      - one-clk SDRAM completion pulse
//   cpu_dtack_n  - DTACK to the CPU
//   mem_req      - level request to the arbiter; mem_region its region
//   bus_error    - one-clk pulse on timeout or unmapped access
//   busy         - controller not idle
module cpu_dtack_ctrl
    import system_consts::*;
#(
    parameter int NUM_CS        = 16,
    parameter int CNT_W         = 4,
    parameter int TIMEOUT       = 255,
    parameter int UNMAPPED_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic              cpu_as_n,
    input  logic [1:0]        cpu_ds_n,
    input  logic [NUM_CS-1:0] cs_n,
    input  logic              mem_ack,
    output logic              cpu_dtack_n,
    output logic              mem_req,
    output logic [3:0]        mem_region,
    output logic              bus_error,
    output logic              busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    dtack_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [3:0]          region_q, region_d;
    logic                unmapped_q, unmapped_d;
    logic                dtack_n_q, dtack_n_d;
    logic                mem_req_q, mem_req_d;
    logic                bus_error_q, bus_error_d;

    logic [$clog2(NUM_CS)-1:0] enc_idx;
    logic                      enc_any;
    logic                      cycle_start;
    logic                      start_mem;
    logic [CNT_W-1:0]          start_cnt;

    cs_priority_enc #(.NUM_CS(NUM_CS)) u_enc (
        .cs_n      (cs_n),
        .idx       (enc_idx),
        .any_valid (enc_any)
    );

    assign cycle_start = cpu_ce && !cpu_as_n && (cpu_ds_n != 2'b11);

    always_comb begin
        start_mem = enc_any && (REGION_CLASS[enc_idx] == WAIT_MEM);
        start_cnt = enc_any ? CNT_W'(REGION_WAIT[enc_idx]) : CNT_W'(UNMAPPED_WAIT);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        region_d    = region_q;
        unmapped_d  = unmapped_q;
        bus_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cycle_start) begin
                    region_d   = enc_any ? 4'(enc_idx) : 4'd0;
                    unmapped_d = !enc_any;
                    tmo_d      = '0;
                    cnt_d      = start_mem ? '0 : start_cnt;
                    if (start_mem) begin
                        state_d = ST_MEM_WAIT;
                    end else if (start_cnt == '0) begin
                        state_d     = ST_ACK;
                        bus_error_d = !enc_any;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
            end

            ST_COUNT: begin
                if (cpu_as_n) begin
                    state_d = ST_IDLE;
                end else if (cpu_ce) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d     = ST_ACK;
                        bus_error_d = unmapped_q;
                    end
                end
            end

            // Priority: abort, then mem_ack, then timeout.
            ST_MEM_WAIT: begin
                if (cpu_as_n) begin
                    state_d = ST_IDLE;
                end else if (mem_ack) begin
                    state_d = ST_ACK;
                end else if (cpu_ce) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d     = ST_ACK;
                        bus_error_d = 1'b1;
                    end
                end
            end

            ST_ACK: begin
                if (cpu_as_n) state_d = ST_END;
            end

            // One dead clk so the strobe that just ended cannot restart us.
            ST_END: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // DTACK lags ACK entry by one clk; mem_req follows MEM_WAIT exactly,
    // so it can only rise again after a pass through IDLE.
    always_comb begin
        dtack_n_d = (state_q != ST_ACK);
        mem_req_d = (state_d == ST_MEM_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            region_q    <= '0;
            unmapped_q  <= 1'b0;
            dtack_n_q   <= 1'b1;
            mem_req_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            region_q    <= region_d;
            unmapped_q  <= unmapped_d;
            dtack_n_q   <= dtack_n_d;
            mem_req_q   <= mem_req_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign cpu_dtack_n = dtack_n_q;
    assign mem_req     = mem_req_q;
    assign mem_region  = region_q;
    assign bus_error   = bus_error_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_dtack_ctrl.sv
module tb_cpu_dtack_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_ce = 1'b0;
    logic        cpu_as_n = 1'b1;
    logic [1:0]  cpu_ds_n = 2'b11;
    logic [15:0] cs_n = 16'hFFFF;
    logic        mem_ack = 1'b0;
    logic        cpu_dtack_n, mem_req, bus_error, busy;
    logic [3:0]  mem_region;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_dtack_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_ce      (cpu_ce),
        .cpu_as_n    (cpu_as_n),
        .cpu_ds_n    (cpu_ds_n),
        .cs_n        (cs_n),
        .mem_ack     (mem_ack),
        .cpu_dtack_n (cpu_dtack_n),
        .mem_req     (mem_req),
        .mem_region  (mem_region),
        .bus_error   (bus_error),
        .busy        (busy)
    );

    // cpu_ce: one pulse every 4 clks
    int ce_div = 0;
    always @(negedge clk) begin
        ce_div = (ce_div + 1) % 4;
        cpu_ce = (ce_div == 0);
    end

    int ce_total = 0;
    int berr_total = 0;
    always @(posedge clk) if (cpu_ce) ce_total++;
    always @(posedge clk) begin
        #2;
        if (bus_error) berr_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Region table as the bench understands it: -1 = SDRAM, else wait count.
    function automatic int region_wait(input int i);
        case (i)
            0, 1:       return -1;
            2, 3, 4, 5: return 1;
            6, 7:       return 2;
            8:          return 3;
            10, 12:     return 1;
            11:         return 4;
            default:    return 0;
        endcase
    endfunction

    // Behavioural model: tracks the bus transaction in progress and what
    // the CPU should see. phase: 0 no cycle, 1 waiting ticks, 2 waiting
    // on SDRAM, 3 acknowledged, 4 strobe released.
    int         m_phase = 0, m_ticks = 0, m_tmo = 0, m_sel;
    bit         m_unm = 0, was_acked;
    logic [3:0] m_region = 0;
    logic       e_dtack_n = 1, e_req = 0, e_berr = 0, e_busy = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_region = 0;
            e_dtack_n = 1; e_req = 0; e_berr = 0; e_busy = 0;
        end else begin
            was_acked = (m_phase == 3);
            e_berr = 0;
            case (m_phase)
                0: if (cpu_ce && !cpu_as_n && cpu_ds_n != 2'b11) begin
                    m_sel = -1;
                    for (int i = 15; i >= 0; i--) if (!cs_n[i]) m_sel = i;
                    m_unm = (m_sel < 0);
                    m_region = m_unm ? 4'd0 : 4'(m_sel);
                    m_tmo = 0;
                    if (!m_unm && region_wait(m_sel) < 0) m_phase = 2;
                    else begin
                        m_ticks = m_unm ? 2 : region_wait(m_sel);
                        if (m_ticks == 0) begin m_phase = 3; e_berr = m_unm; end
                        else m_phase = 1;
                    end
                end
                1: if (cpu_as_n) m_phase = 0;
                   else if (cpu_ce) begin
                       m_ticks--;
                       if (m_ticks == 0) begin m_phase = 3; e_berr = m_unm; end
                   end
                2: if (cpu_as_n) m_phase = 0;
                   else if (mem_ack) m_phase = 3;
                   else if (cpu_ce) begin
                       m_tmo++;
                       if (m_tmo == 255) begin m_phase = 3; e_berr = 1; end
                   end
                3: if (cpu_as_n) m_phase = 4;
                default: m_phase = 0;
            endcase
            e_dtack_n = !was_acked;
            e_req     = (m_phase == 2);
            e_busy    = (m_phase != 0);
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("model_dtack_n", cpu_dtack_n, e_dtack_n);
            chk("model_mem_req", mem_req, e_req);
            chk("model_bus_error", bus_error, e_berr);
            chk("model_busy", busy, e_busy);
            if (e_req) chk("model_mem_region", mem_region, m_region);
        end
    end

    task automatic go(input logic [15:0] sel);
        @(negedge clk);
        cs_n = sel; cpu_as_n = 1'b0; cpu_ds_n = 2'b10;
    endtask

    task automatic release_bus();
        @(negedge clk);
        cpu_as_n = 1'b1; cpu_ds_n = 2'b11; cs_n = 16'hFFFF;
    endtask

    task automatic wait_busy(input logic lvl, input int bound, output int ce_at);
        int n = 0;
        while (busy !== lvl && n < bound) begin @(negedge clk); n++; end
        chk("wait_busy", busy, lvl);
        ce_at = ce_total;
    endtask

    task automatic wait_dtack(input int bound, output int ce_at);
        int n = 0;
        while (cpu_dtack_n !== 1'b0 && n < bound) begin @(negedge clk); n++; end
        chk("wait_dtack", cpu_dtack_n, 1'b0);
        ce_at = ce_total;
    endtask

    task automatic wait_req(input int bound, output int ce_at);
        int n = 0;
        while (mem_req !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        chk("wait_mem_req", mem_req, 1'b1);
        ce_at = ce_total;
    endtask

    task automatic pulse_ack();
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
    endtask

    initial begin
        int c0, c1, b0, dummy;

        repeat (3) @(negedge clk);
        chk("reset_dtack_n", cpu_dtack_n, 1'b1);
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_region", mem_region, 4'd0);
        chk("reset_bus_error", bus_error, 1'b0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;
        cmp_en = 1;

        // fixed wait of 1 (COLOR)
        b0 = berr_total;
        go(~(16'd1 << 5));
        wait_busy(1'b1, 20, c0);
        wait_dtack(20, c1);
        chk("color_ce_wait", c1 - c0, 1);
        release_bus();
        repeat (2) @(negedge clk);
        chk("color_release_dtack", cpu_dtack_n, 1'b1);
        chk("color_release_busy", busy, 1'b0);
        chk("color_no_berr", berr_total - b0, 0);

        // ROM via SDRAM, ack 7 clks into MEM_WAIT
        go(~16'd1);
        wait_req(20, dummy);
        chk("rom_region", mem_region, 4'd0);
        repeat (5) @(negedge clk);
        pulse_ack();
        chk("rom_req_drop", mem_req, 1'b0);
        chk("rom_dtack_lag", cpu_dtack_n, 1'b1);
        @(negedge clk);
        chk("rom_dtack", cpu_dtack_n, 1'b0);
        chk("rom_no_berr", berr_total - b0, 0);
        release_bus();
        wait_busy(1'b0, 10, dummy);

        // WORK with no ack: timeout after 255 cpu_ce pulses
        go(~16'd2);
        wait_req(20, c0);
        chk("work_region", mem_region, 4'd1);
        b0 = berr_total;
        wait_dtack(1200, c1);
        chk("timeout_ce", c1 - c0, 255);
        chk("timeout_berr", berr_total - b0, 1);
        chk("timeout_req_drop", mem_req, 1'b0);
        release_bus();
        wait_busy(1'b0, 10, dummy);

        // unmapped
        b0 = berr_total;
        go(16'hFFFF);
        wait_busy(1'b1, 20, c0);
        wait_dtack(20, c1);
        chk("unmapped_ce_wait", c1 - c0, 2);
        chk("unmapped_berr", berr_total - b0, 1);
        release_bus();
        wait_busy(1'b0, 10, dummy);

        // zero-wait region (EXTENSION)
        b0 = berr_total;
        go(~(16'd1 << 9));
        wait_busy(1'b1, 20, c0);
        wait_dtack(5, c1);
        chk("zero_wait_ce", c1 - c0, 0);
        chk("zero_wait_no_berr", berr_total - b0, 0);
        release_bus();
        wait_busy(1'b0, 10, dummy);

        // abort in MEM_WAIT, stray ack, then a normal ROM cycle
        go(~16'd1);
        wait_req(20, dummy);
        repeat (3) @(negedge clk);
        release_bus();
        @(negedge clk);
        chk("abort_req", mem_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_dtack", cpu_dtack_n, 1'b1);
        repeat (3) @(negedge clk);
        pulse_ack();
        repeat (2) @(negedge clk);
        chk("stray_ack_busy", busy, 1'b0);
        chk("stray_ack_dtack", cpu_dtack_n, 1'b1);
        go(~16'd1);
        wait_req(20, dummy);
        repeat (2) @(negedge clk);
        pulse_ack();
        wait_dtack(5, dummy);
        chk("abort_no_berr", berr_total - b0, 0);
        release_bus();
        wait_busy(1'b0, 10, dummy);

        // async reset while acknowledged
        go(~(16'd1 << 5));
        wait_dtack(20, dummy);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_dtack", cpu_dtack_n, 1'b1);
        chk("async_rst_req", mem_req, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        release_bus();
        @(negedge clk);
        reset = 1'b0;

        // IO0 and ROM selected together: ROM wins
        go(~((16'd1 << 0) | (16'd1 << 6)));
        wait_req(20, dummy);
        chk("prio_region", mem_region, 4'd0);
        pulse_ack();
        wait_dtack(5, dummy);
        release_bus();
        wait_busy(1'b0, 10, dummy);

        repeat (2) @(negedge clk);
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_dtack_ctrl.md
Name: cpu_dtack_ctrl

Overview:
- Sits directly downstream of the 68000 address decoder; consumes its active-low region selects and drives CPU DTACK.
- Per region it applies either a fixed wait-state count or an SDRAM request/acknowledge handshake (ROM, work RAM).
- A timeout guard ensures a bus cycle never hangs the CPU; unmapped accesses are acknowledged and flagged.

Parameters:
- NUM_CS, 16, number of decoded region selects (matches cs_idx_t in package)
- CNT_W, 4, width of the fixed-wait counter
- TIMEOUT, 255, max cpu_ce pulses spent in MEM_WAIT before forced DTACK
- UNMAPPED_WAIT, 2, cpu_ce pulses before DTACK when no select is active

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_ce  in  1  one-clk pulse per CPU clock; all wait counting is in cpu_ce units
- cpu_as_n  in  1  CPU address strobe
- cpu_ds_n  in  2  CPU data strobes {UDS, LDS}
- cs_n  in  NUM_CS  active-low region selects from the decoder, indexed by cs_idx_t
- mem_ack  in  1  one-clk pulse from SDRAM arbiter: data ready / write accepted
- cpu_dtack_n  out  1  DTACK to CPU
- mem_req  out  1  level request to SDRAM arbiter for the latched region
- mem_region  out  4  latched region index (valid while mem_req = 1)
- bus_error  out  1  one-clk pulse on timeout or unmapped access
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state = IDLE, cpu_dtack_n = 1, mem_req = 0, mem_region = 0, bus_error = 0, counters = 0.
- Cycle start: in IDLE, on a clk with cpu_ce = 1, cpu_as_n = 0 and cpu_ds_n != 2'b11, the block latches region = lowest index i with cs_n[i] = 0 (fixed priority encoder).
- Region class comes from the package table REGION_CLASS[i]: WAIT_FIXED (count = REGION_WAIT[i]) or WAIT_MEM.
  - No select low: class UNMAPPED, count = UNMAPPED_WAIT.
- States and transitions:
  - IDLE: on cycle start go to COUNT (fixed or unmapped) or MEM_WAIT (mem). If count = 0, go directly to ACK.
  - COUNT: decrement on each cpu_ce; on reaching 0 go to ACK. Unmapped: bus_error pulses on entry to ACK.
  - MEM_WAIT: mem_req = 1 and mem_region = region from the first clk of MEM_WAIT.
    - mem_ack (sampled every clk, not gated by cpu_ce) → mem_req drops the next clk, go to ACK.
    - Timeout counter increments per cpu_ce; reaching TIMEOUT → drop mem_req, pulse bus_error, go to ACK.
  - ACK: cpu_dtack_n = 0 (registered, changes on the clk after entry). Hold until cpu_as_n = 1 sampled, then go to END.
  - END: cpu_dtack_n = 1; go to IDLE the next clk. Prevents re-triggering on the same strobe.
- Abort: cpu_as_n = 1 seen in COUNT or MEM_WAIT (CPU reset or savestate override) → drop mem_req and go to IDLE with no DTACK.
  - A mem_ack arriving while in IDLE, or for an aborted request, is ignored.
- Simultaneous events:
  - mem_ack on the same clk as the timeout → mem_ack wins, no bus_error.
  - Abort on the same clk as mem_ack → abort wins.
- Multiple selects low: lowest index wins. This is legal and not flagged.
- mem_req never toggles within a cycle; a new request requires passing through IDLE.

Decomposition:
- Package system_consts gains:
  - cs_idx_t enum (CS_ROM = 0, CS_WORK, CS_SCREEN0, CS_SCREEN1, CS_OBJECT, CS_COLOR, CS_IO0, CS_IO1, CS_SOUND, CS_EXTENSION, CS_PRIORITY, CS_CCHIP, CS_PIVOT, CS_GROWL_HACK, CS_SS_SAVE, CS_SS_VEC)
  - wait_class_t enum (WAIT_FIXED, WAIT_MEM)
  - REGION_CLASS and REGION_WAIT constant arrays
- One natural sub-module: cs_priority_enc (NUM_CS → index + any_valid), combinational.

Test Plan:
- cs_n[CS_COLOR] = 0, REGION_WAIT = 1, AS/LDS low → DTACK low exactly one cpu_ce after start. AS high → DTACK high within 2 clks; busy = 0.
- cs_n[CS_ROM] = 0 → mem_req = 1, mem_region = 0. mem_ack after 7 clks → mem_req = 0 next clk, DTACK low the following clk, no bus_error.
- CS_WORK request, mem_ack never arrives → after 255 cpu_ce pulses: one-clk bus_error, mem_req = 0, DTACK = 0.
- All cs_n = 1 with AS low → DTACK after 2 cpu_ce pulses, bus_error pulses once.
- CS_ROM in MEM_WAIT, AS driven high before ack → mem_req = 0 and IDLE, no DTACK. A later mem_ack is ignored; the next ROM cycle behaves normally.
- reset asserted mid-ACK → cpu_dtack_n = 1 and mem_req = 0 immediately (async). cs_n[CS_IO0] = 0 and cs_n[CS_ROM] = 0 together → ROM path taken.
